// File: rtl/mul_ctrl_pkg.sv
// Shared op/state encodings and op-class helpers for the multiply sequencing controller.
package mul_ctrl_pkg;

    typedef enum logic [2:0] {
        OpNop   = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpMul   = 3'd3,
        OpMadd  = 3'd4,
        OpMaddu = 3'd5,
        OpMsub  = 3'd6,
        OpMsubu = 3'd7
    } mul_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone,
        StAbort
    } state_e;

    function automatic logic is_signed(input mul_op_e op);
        return (op == OpMult) || (op == OpMul) || (op == OpMadd) || (op == OpMsub);
    endfunction

    function automatic logic is_acc(input mul_op_e op);
        return (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
    endfunction

    function automatic logic is_sub(input mul_op_e op);
        return (op == OpMsub) || (op == OpMsubu);
    endfunction

    function automatic logic writes_gpr(input mul_op_e op);
        return op == OpMul;
    endfunction

endpackage

// File: rtl/mul_ctrl.sv
// Sequences one multiply-class op through the iterative multiplier: holds the start handshake,
// stalls EX while busy, applies HI/LO accumulate/subtract and issues a one-cycle writeback.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [2:0]  ex_op_i,
    input  logic [31:0] ex_rs_i,
    input  logic [31:0] ex_rt_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        mul_start_o,
    output logic        mul_annul_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        gpr_we_o,
    output logic [31:0] gpr_wdata_o,
    output logic        timeout_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e          state_q;
    mul_op_e         op_q;
    logic [31:0]     rs_q;
    logic [31:0]     rt_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic            signed_q;
    logic [63:0]     res_q;
    logic [63:0]     res_d;
    logic [CntW-1:0] cnt_q;
    logic            accept;

    assign accept = (state_q == StIdle) && ex_valid_i && (ex_op_i != OpNop) && !flush_i;

    assign stall_req_o = accept || (state_q == StBusy) || ((state_q == StAbort) && ex_valid_i);

    assign mul_signed_o = signed_q;
    assign mul_op1_o    = rs_q;
    assign mul_op2_o    = rt_q;

    // A flush landing in the DONE cycle must still kill the writeback, so the strobes stay
    // combinational on flush_i.
    assign hilo_we_o   = (state_q == StDone) && !flush_i && !writes_gpr(op_q);
    assign gpr_we_o    = (state_q == StDone) && !flush_i && writes_gpr(op_q);
    assign hi_o        = res_q[63:32];
    assign lo_o        = res_q[31:0];
    assign gpr_wdata_o = res_q[31:0];

    always_comb begin
        res_d = mul_result_i;
        if (is_acc(op_q)) begin
            res_d = is_sub(op_q) ? ({hi_q, lo_q} - mul_result_i)
                                 : ({hi_q, lo_q} + mul_result_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpNop;
            rs_q        <= '0;
            rt_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            signed_q    <= 1'b0;
            res_q       <= '0;
            cnt_q       <= '0;
            mul_start_o <= 1'b0;
            mul_annul_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            mul_annul_o <= 1'b0;
            timeout_o   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q        <= mul_op_e'(ex_op_i);
                        rs_q        <= ex_rs_i;
                        rt_q        <= ex_rt_i;
                        hi_q        <= hi_i;
                        lo_q        <= lo_i;
                        signed_q    <= is_signed(mul_op_e'(ex_op_i));
                        cnt_q       <= '0;
                        mul_start_o <= 1'b1;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (flush_i) begin
                        mul_start_o <= 1'b0;
                        mul_annul_o <= 1'b1;
                        state_q     <= StAbort;
                    end else if (mul_ready_i) begin
                        res_q       <= res_d;
                        mul_start_o <= 1'b0;
                        state_q     <= StDone;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        mul_start_o <= 1'b0;
                        mul_annul_o <= 1'b1;
                        timeout_o   <= 1'b1;
                        state_q     <= StAbort;
                    end
                end
                StDone:  state_q <= StIdle;
                StAbort: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a behavioural iterative-multiplier model attached.
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    localparam int unsigned TIMEOUT = 48;
    localparam int          LAT     = 35;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic [2:0]  ex_op_i = '0;
    logic [31:0] ex_rs_i = '0;
    logic [31:0] ex_rt_i = '0;
    logic [31:0] hi_i = '0;
    logic [31:0] lo_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_req_o;
    logic        mul_start_o;
    logic        mul_annul_o;
    logic        mul_signed_o;
    logic [31:0] mul_op1_o;
    logic [31:0] mul_op2_o;
    logic [63:0] mul_result_i = '0;
    logic        mul_ready_i = 1'b0;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        gpr_we_o;
    logic [31:0] gpr_wdata_o;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;
    logic tie_ready_low = 1'b0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid_i   (ex_valid_i),
        .ex_op_i      (ex_op_i),
        .ex_rs_i      (ex_rs_i),
        .ex_rt_i      (ex_rt_i),
        .hi_i         (hi_i),
        .lo_i         (lo_i),
        .flush_i      (flush_i),
        .stall_req_o  (stall_req_o),
        .mul_start_o  (mul_start_o),
        .mul_annul_o  (mul_annul_o),
        .mul_signed_o (mul_signed_o),
        .mul_op1_o    (mul_op1_o),
        .mul_op2_o    (mul_op2_o),
        .mul_result_i (mul_result_i),
        .mul_ready_i  (mul_ready_i),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .gpr_we_o     (gpr_we_o),
        .gpr_wdata_o  (gpr_wdata_o),
        .timeout_o    (timeout_o)
    );

    // Iterative multiplier stand-in: ready LAT cycles after start, freed by start=0 or annul.
    always @(posedge clk) begin
        if (rst || mul_annul_o || !mul_start_o) begin
            m_cnt       <= 0;
            mul_ready_i <= 1'b0;
        end else if (!mul_ready_i && !tie_ready_low) begin
            if (m_cnt == LAT - 1) begin
                mul_ready_i <= 1'b1;
                if (mul_signed_o)
                    mul_result_i <= $signed({{32{mul_op1_o[31]}}, mul_op1_o})
                                  * $signed({{32{mul_op2_o[31]}}, mul_op2_o});
                else
                    mul_result_i <= {32'd0, mul_op1_o} * {32'd0, mul_op2_o};
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] rs,
                                               input logic [31:0] rt, input logic [31:0] h,
                                               input logic [31:0] l);
        longint p;
        logic [63:0] base;
        base = {h, l};
        if (op == 3'd1 || op == 3'd3 || op == 3'd4 || op == 3'd6)
            p = longint'(signed'(rs)) * longint'(signed'(rt));
        else
            p = longint'({32'd0, rs} * {32'd0, rt});
        if (op == 3'd4 || op == 3'd5) return base + 64'(p);
        if (op == 3'd6 || op == 3'd7) return base - 64'(p);
        return 64'(p);
    endfunction

    typedef struct {
        int          n_hilo;
        int          n_gpr;
        int          n_annul;
        int          n_to;
        int          busy;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] gw;
        bit          stall_ok;
        bit          sig_ok;
        bit          finished;
        bit          zero_after;
    } obs_t;

    // Issues one op from IDLE (called at negedge+1) and observes it until the controller
    // leaves BUSY, plus one trailing IDLE cycle to catch stray strobes.
    task automatic issue_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] h, input logic [31:0] l, input int flush_at,
                            input int rst_at, input bit flush_done, output obs_t o);
        bit prev_ready;
        bit exp_sig;
        o.n_hilo = 0; o.n_gpr = 0; o.n_annul = 0; o.n_to = 0; o.busy = 0;
        o.hi = '0; o.lo = '0; o.gw = '0;
        o.stall_ok = 1'b1; o.sig_ok = 1'b1; o.finished = 1'b0; o.zero_after = 1'b0;
        prev_ready = 1'b0;
        exp_sig = (op == 3'd1 || op == 3'd3 || op == 3'd4 || op == 3'd6);
        ex_op_i = op; ex_rs_i = rs; ex_rt_i = rt; hi_i = h; lo_i = l;
        ex_valid_i = 1'b1; flush_i = 1'b0;
        #1;
        if (!stall_req_o) o.stall_ok = 1'b0;
        for (int c = 0; c < 200 && !o.finished; c++) begin
            @(negedge clk);
            ex_valid_i = 1'b0;
            flush_i = (flush_at >= 0 && mul_start_o && o.busy == flush_at) ||
                      (flush_done && prev_ready && !mul_start_o);
            rst = (rst_at >= 0 && mul_start_o && o.busy == rst_at);
            #1;
            if (mul_start_o) begin
                o.busy++;
                if (!stall_req_o) o.stall_ok = 1'b0;
                if (mul_signed_o !== exp_sig || mul_op1_o !== rs || mul_op2_o !== rt)
                    o.sig_ok = 1'b0;
                prev_ready = mul_ready_i;
            end else begin
                if (!mul_annul_o && stall_req_o) o.stall_ok = 1'b0;
                o.finished = 1'b1;
                o.zero_after = hi_o == 0 && lo_o == 0 && gpr_wdata_o == 0 && mul_op1_o == 0 &&
                               mul_op2_o == 0 && !mul_annul_o && !hilo_we_o && !gpr_we_o &&
                               !timeout_o && !mul_signed_o;
            end
            if (hilo_we_o) begin o.n_hilo++; o.hi = hi_o; o.lo = lo_o; end
            if (gpr_we_o) begin o.n_gpr++; o.gw = gpr_wdata_o; end
            if (mul_annul_o) o.n_annul++;
            if (timeout_o) o.n_to++;
        end
        @(negedge clk);
        flush_i = 1'b0; rst = 1'b0;
        #1;
        if (hilo_we_o) o.n_hilo++;
        if (gpr_we_o) o.n_gpr++;
        if (mul_annul_o) o.n_annul++;
        if (timeout_o) o.n_to++;
        checks++;
        if (!o.finished) begin
            errors++;
            $display("FAIL op_bound: controller still busy after 200 cycles (op=%0d)", op);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stall_req_o, mul_start_o, mul_annul_o, hilo_we_o, gpr_we_o, timeout_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {stall_req_o, mul_start_o,
                     mul_annul_o, hilo_we_o, gpr_we_o, timeout_o});
        end
        checks++;
        if ({hi_o, lo_o, gpr_wdata_o, mul_op1_o, mul_op2_o} !== 160'b0) begin
            errors++;
            $display("FAIL reset_data: got hi=%h lo=%h gw=%h op1=%h op2=%h want 0",
                     hi_o, lo_o, gpr_wdata_o, mul_op1_o, mul_op2_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_multu_max();
        obs_t o;
        issue_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, -1, -1, 1'b0, o);
        checks++;
        if (o.n_hilo !== 1 || o.n_gpr !== 0) begin
            errors++;
            $display("FAIL multu_strobes: got hilo=%0d gpr=%0d want 1 0", o.n_hilo, o.n_gpr);
        end
        checks++;
        if ({o.hi, o.lo} !== 64'hFFFFFFFE_00000001) begin
            errors++;
            $display("FAIL multu_value: got %h%h want fffffffe00000001", o.hi, o.lo);
        end
        checks++;
        if (!o.stall_ok || !o.sig_ok) begin
            errors++;
            $display("FAIL multu_stall_sig: got stall_ok=%0d sig_ok=%0d want 1 1",
                     o.stall_ok, o.sig_ok);
        end
    endtask

    task automatic test_mult_signed();
        obs_t o;
        issue_op(OpMult, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, -1, -1, 1'b0, o);
        checks++;
        if (o.n_hilo !== 1 || {o.hi, o.lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
            errors++;
            $display("FAIL mult_value: got n=%0d %h%h want 1 fffffffffffffff1",
                     o.n_hilo, o.hi, o.lo);
        end
        checks++;
        if (!o.sig_ok) begin
            errors++;
            $display("FAIL mult_signed: got sig_ok=0 want 1");
        end
    endtask

    task automatic test_mul_gpr();
        obs_t o;
        issue_op(OpMul, 32'd7, 32'd6, 32'h12345678, 32'h9ABCDEF0, -1, -1, 1'b0, o);
        checks++;
        if (o.n_gpr !== 1 || o.gw !== 32'd42 || o.n_hilo !== 0) begin
            errors++;
            $display("FAIL mul_gpr: got gpr=%0d wdata=%0d hilo=%0d want 1 42 0",
                     o.n_gpr, o.gw, o.n_hilo);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        issue_op(OpMadd, 32'd2, 32'd1, 32'h0, 32'hFFFFFFFF, -1, -1, 1'b0, o);
        checks++;
        if (o.n_hilo !== 1 || o.hi !== 32'd1 || o.lo !== 32'd1) begin
            errors++;
            $display("FAIL madd_value: got n=%0d hi=%h lo=%h want 1 1 1", o.n_hilo, o.hi, o.lo);
        end
        issue_op(OpMsubu, 32'd1, 32'd1, 32'h0, 32'h0, -1, -1, 1'b0, o);
        checks++;
        if (o.n_hilo !== 1 || o.hi !== 32'hFFFFFFFF || o.lo !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL msubu_value: got n=%0d hi=%h lo=%h want 1 ffffffff ffffffff",
                     o.n_hilo, o.hi, o.lo);
        end
    endtask

    task automatic test_flush_busy();
        obs_t o;
        issue_op(OpMultu, 32'd9, 32'd9, 32'h0, 32'h0, 10, -1, 1'b0, o);
        checks++;
        if (o.n_annul !== 1 || o.n_hilo !== 0 || o.n_gpr !== 0 || o.n_to !== 0 || o.busy !== 11)
        begin
            errors++;
            $display("FAIL flush_busy: got annul=%0d hilo=%0d gpr=%0d to=%0d busy=%0d want 1 0 0 0 11",
                     o.n_annul, o.n_hilo, o.n_gpr, o.n_to, o.busy);
        end
        issue_op(OpMultu, 32'd3, 32'd4, 32'h0, 32'h0, -1, -1, 1'b0, o);
        checks++;
        if (o.n_hilo !== 1 || o.hi !== 32'd0 || o.lo !== 32'd12) begin
            errors++;
            $display("FAIL after_flush: got n=%0d hi=%h lo=%h want 1 0 c", o.n_hilo, o.hi, o.lo);
        end
    endtask

    task automatic test_reset_busy();
        obs_t o;
        logic [63:0] exp;
        issue_op(OpMultu, 32'd9, 32'd9, 32'h0, 32'h0, -1, 20, 1'b0, o);
        checks++;
        if (!o.zero_after || o.n_hilo !== 0 || o.n_gpr !== 0 || o.n_annul !== 0) begin
            errors++;
            $display("FAIL reset_busy: got zero=%0d hilo=%0d gpr=%0d annul=%0d want 1 0 0 0",
                     o.zero_after, o.n_hilo, o.n_gpr, o.n_annul);
        end
        exp = ref_result(OpMsub, 32'hDEAD0001, 32'h00C0FFEE, 32'h11111111, 32'h22222222);
        issue_op(OpMsub, 32'hDEAD0001, 32'h00C0FFEE, 32'h11111111, 32'h22222222, -1, -1, 1'b0, o);
        checks++;
        if (o.n_hilo !== 1 || {o.hi, o.lo} !== exp) begin
            errors++;
            $display("FAIL after_reset: got n=%0d %h%h want 1 %h", o.n_hilo, o.hi, o.lo, exp);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        tie_ready_low = 1'b1;
        issue_op(OpMult, 32'd5, 32'd5, 32'h0, 32'h0, -1, -1, 1'b0, o);
        tie_ready_low = 1'b0;
        checks++;
        if (o.busy !== int'(TIMEOUT) || o.n_to !== 1 || o.n_annul !== 1 ||
            o.n_hilo !== 0 || o.n_gpr !== 0) begin
            errors++;
            $display("FAIL timeout: got busy=%0d to=%0d annul=%0d hilo=%0d gpr=%0d want %0d 1 1 0 0",
                     o.busy, o.n_to, o.n_annul, o.n_hilo, o.n_gpr, TIMEOUT);
        end
        issue_op(OpMultu, 32'd3, 32'd4, 32'h0, 32'h0, -1, -1, 1'b0, o);
        checks++;
        if (o.n_hilo !== 1 || {o.hi, o.lo} !== 64'd12) begin
            errors++;
            $display("FAIL after_timeout: got n=%0d %h%h want 1 c", o.n_hilo, o.hi, o.lo);
        end
    endtask

    task automatic test_flush_done();
        obs_t o;
        issue_op(OpMul, 32'd7, 32'd6, 32'h0, 32'h0, -1, -1, 1'b1, o);
        checks++;
        if (o.n_hilo !== 0 || o.n_gpr !== 0 || o.n_annul !== 0) begin
            errors++;
            $display("FAIL flush_done_mul: got hilo=%0d gpr=%0d annul=%0d want 0 0 0",
                     o.n_hilo, o.n_gpr, o.n_annul);
        end
        issue_op(OpMaddu, 32'd7, 32'd6, 32'h0, 32'h0, -1, -1, 1'b1, o);
        checks++;
        if (o.n_hilo !== 0 || o.n_gpr !== 0) begin
            errors++;
            $display("FAIL flush_done_hilo: got hilo=%0d gpr=%0d want 0 0", o.n_hilo, o.n_gpr);
        end
    endtask

    task automatic test_idle_block();
        ex_op_i = OpMult; ex_valid_i = 1'b1; flush_i = 1'b1;
        #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_stall: got %b want 0", stall_req_o);
        end
        @(negedge clk);
        ex_op_i = OpNop; flush_i = 1'b0;
        #1;
        checks++;
        if (mul_start_o !== 1'b0 || stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_block: got start=%b stall=%b want 0 0", mul_start_o, stall_req_o);
        end
        @(negedge clk);
        ex_valid_i = 1'b0;
        #1;
        checks++;
        if (mul_start_o !== 1'b0) begin
            errors++;
            $display("FAIL nop_start: got %b want 0", mul_start_o);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0] op;
        logic [31:0] rs, rt, h, l;
        logic [63:0] exp;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(7, 1));
            rs = $urandom; rt = $urandom; h = $urandom; l = $urandom;
            exp = ref_result(op, rs, rt, h, l);
            issue_op(op, rs, rt, h, l, -1, -1, 1'b0, o);
            checks++;
            if (op == 3'd3) begin
                if (o.n_gpr !== 1 || o.n_hilo !== 0 || o.gw !== exp[31:0]) begin
                    errors++;
                    $display("FAIL rand_mul[%0d]: got gpr=%0d hilo=%0d wdata=%h want 1 0 %h",
                             i, o.n_gpr, o.n_hilo, o.gw, exp[31:0]);
                end
            end else if (o.n_hilo !== 1 || o.n_gpr !== 0 || {o.hi, o.lo} !== exp) begin
                errors++;
                $display("FAIL rand_op%0d[%0d]: got hilo=%0d gpr=%0d %h%h want 1 0 %h",
                         op, i, o.n_hilo, o.n_gpr, o.hi, o.lo, exp);
            end
            checks++;
            if (!o.stall_ok || !o.sig_ok) begin
                errors++;
                $display("FAIL rand_hs[%0d]: got stall_ok=%0d sig_ok=%0d want 1 1",
                         i, o.stall_ok, o.sig_ok);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_mul_gpr();
        test_back_to_back();
        test_flush_busy();
        test_reset_busy();
        test_timeout();
        test_flush_done();
        test_idle_block();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
